// File: rtl/gp_writeback_arbiter_pkg.sv
// Shared types and constants for the GPR writeback arbiter and its scoreboard.
// The optional forwarding path is enabled with GP_WB_FORWARD_EN.
package gp_writeback_arbiter_pkg;

    localparam int REG_IDX_W = 5;
    localparam int XLEN      = 32;
    localparam int NUM_REGS  = 32;

    localparam logic [NUM_REGS-1:0] REG_BIT0 = 32'd1;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [XLEN-1:0]      xlen_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_ALU  = 2'd1,
        GNT_LD   = 2'd2
    } gnt_e;

endpackage

// File: rtl/gp_writeback_arbiter_if.sv
// Writeback bus: two producer handshakes and the register-file write port.
// Producers and the register file form the master side; the arbiter is the slave.
interface gp_writeback_arbiter_if;
    import gp_writeback_arbiter_pkg::*;

    logic     alu_valid;
    logic     alu_ready;
    reg_idx_t alu_idx;
    xlen_t    alu_data;
    logic     ld_valid;
    logic     ld_ready;
    reg_idx_t ld_idx;
    xlen_t    ld_data;
    logic     wr_en;
    reg_idx_t wr_idx;
    xlen_t    wr_data;

    modport master (
        output alu_valid, alu_idx, alu_data, ld_valid, ld_idx, ld_data,
        input  alu_ready, ld_ready, wr_en, wr_idx, wr_data
    );

    modport slave (
        input  alu_valid, alu_idx, alu_data, ld_valid, ld_idx, ld_data,
        output alu_ready, ld_ready, wr_en, wr_idx, wr_data
    );

endinterface

// File: rtl/gp_writeback_arbiter_scoreboard.sv
// gp_scoreboard: 32-entry busy vector for outstanding register writes.
// x0 can never be marked busy; an allocation beats a same-edge retirement.
module gp_scoreboard
    import gp_writeback_arbiter_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     set_en_i,
    input  reg_idx_t set_idx_i,
    input  logic     clr_en_i,
    input  reg_idx_t clr_idx_i,
    input  reg_idx_t chk_idx_1_i,
    input  reg_idx_t chk_idx_2_i,
    output logic     busy_1_o,
    output logic     busy_2_o
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [NUM_REGS-1:0] set_mask_s;
    logic [NUM_REGS-1:0] clr_mask_s;

    // Clear mask applied before set mask so alloc wins on a collision.
    always_comb begin
        set_mask_s = (set_en_i && (set_idx_i != 5'd0)) ? (REG_BIT0 << set_idx_i) : 32'd0;
        clr_mask_s = clr_en_i ? (REG_BIT0 << clr_idx_i) : 32'd0;
        busy_d     = ((busy_q & ~clr_mask_s) | set_mask_s) & ~REG_BIT0;
    end

    // Busy vector state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 32'd0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_1_o = busy_q[chk_idx_1_i];
    assign busy_2_o = busy_q[chk_idx_2_i];

endmodule

// File: rtl/gp_writeback_arbiter.sv
// Arbitrates the single GPR write port between ALU and load writeback, with
// starvation protection for loads. Define GP_WB_FORWARD_EN for the bypass outputs.
module gp_writeback_arbiter
    import gp_writeback_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    gp_writeback_arbiter_if.slave        wb,
    input  logic                         alloc_en,
    input  reg_idx_t                     alloc_idx,
    input  reg_idx_t                     chk_idx_1,
    input  reg_idx_t                     chk_idx_2,
    output logic                         busy_1,
    output logic                         busy_2
`ifdef GP_WB_FORWARD_EN
    ,
    output xlen_t                        fwd_data_1,
    output xlen_t                        fwd_data_2
`endif
);

    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    gnt_e             gnt_s;
    reg_idx_t         win_idx_s;
    xlen_t            win_data_s;
    logic             wr_en_q;
    logic             wr_en_d;
    reg_idx_t         wr_idx_q;
    reg_idx_t         wr_idx_d;
    xlen_t            wr_data_q;
    xlen_t            wr_data_d;
    logic             sb_busy_1_s;
    logic             sb_busy_2_s;

    // Grant selection: load wins when it is alone or has hit the starvation limit.
    always_comb begin
        gnt_s = GNT_NONE;
        if (wb.ld_valid && (!wb.alu_valid || (cnt_q == LIMIT))) begin
            gnt_s = GNT_LD;
        end else if (wb.alu_valid) begin
            gnt_s = GNT_ALU;
        end else begin
            gnt_s = GNT_NONE;
        end
    end

    assign wb.alu_ready = (gnt_s == GNT_ALU);
    assign wb.ld_ready  = (gnt_s == GNT_LD);

    // Next-state for the starvation counter, output register and winner mux.
    always_comb begin
        cnt_d = cnt_q;
        if (!wb.ld_valid || (gnt_s == GNT_LD)) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (cnt_q < LIMIT) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end

        case (gnt_s)
            GNT_ALU: begin
                win_idx_s  = wb.alu_idx;
                win_data_s = wb.alu_data;
            end
            GNT_LD: begin
                win_idx_s  = wb.ld_idx;
                win_data_s = wb.ld_data;
            end
            default: begin
                win_idx_s  = wr_idx_q;
                win_data_s = wr_data_q;
            end
        endcase

        // A granted write to x0 retires the handshake without touching the file.
        wr_en_d   = (gnt_s != GNT_NONE) && (win_idx_s != 5'd0);
        wr_idx_d  = win_idx_s;
        wr_data_d = win_data_s;
    end

    // Counter and write-port registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= {CNT_W{1'b0}};
            wr_en_q   <= 1'b0;
            wr_idx_q  <= 5'd0;
            wr_data_q <= 32'd0;
        end else begin
            cnt_q     <= cnt_d;
            wr_en_q   <= wr_en_d;
            wr_idx_q  <= wr_idx_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign wb.wr_en   = wr_en_q;
    assign wb.wr_idx  = wr_idx_q;
    assign wb.wr_data = wr_data_q;

    gp_scoreboard u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .set_en_i    (alloc_en),
        .set_idx_i   (alloc_idx),
        .clr_en_i    (wr_en_q),
        .clr_idx_i   (wr_idx_q),
        .chk_idx_1_i (chk_idx_1),
        .chk_idx_2_i (chk_idx_2),
        .busy_1_o    (sb_busy_1_s),
        .busy_2_o    (sb_busy_2_s)
    );

`ifdef GP_WB_FORWARD_EN
    // The write being committed this cycle is bypassed, so its source is not busy.
    assign busy_1     = sb_busy_1_s && !(wr_en_q && (wr_idx_q == chk_idx_1));
    assign busy_2     = sb_busy_2_s && !(wr_en_q && (wr_idx_q == chk_idx_2));
    assign fwd_data_1 = wr_data_q;
    assign fwd_data_2 = wr_data_q;
`else
    assign busy_1 = sb_busy_1_s;
    assign busy_2 = sb_busy_2_s;
`endif

endmodule

// File: tb/tb_gp_writeback_arbiter.sv
// Self-checking bench for gp_writeback_arbiter against a behavioural model.
// Also covers the forwarding outputs when GP_WB_FORWARD_EN is defined.
module tb_gp_writeback_arbiter;
    import gp_writeback_arbiter_pkg::*;

    localparam int STARVE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        alloc_en;
    logic [4:0]  alloc_idx;
    logic [4:0]  chk_idx_1;
    logic [4:0]  chk_idx_2;
    logic        busy_1;
    logic        busy_2;
`ifdef GP_WB_FORWARD_EN
    logic [31:0] fwd_data_1;
    logic [31:0] fwd_data_2;
`endif

    gp_writeback_arbiter_if wb_if ();

    gp_writeback_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .CNT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .wb         (wb_if),
        .alloc_en   (alloc_en),
        .alloc_idx  (alloc_idx),
        .chk_idx_1  (chk_idx_1),
        .chk_idx_2  (chk_idx_2),
        .busy_1     (busy_1),
        .busy_2     (busy_2)
`ifdef GP_WB_FORWARD_EN
        ,
        .fwd_data_1 (fwd_data_1),
        .fwd_data_2 (fwd_data_2)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    bit          busy_m [32];
    int          starve_m;
    bit          m_wr_en;
    logic [4:0]  m_wr_idx;
    logic [31:0] m_wr_data;
    bit          g_alu;
    bit          g_ld;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) busy_m[i] = 1'b0;
        starve_m  = 0;
        m_wr_en   = 1'b0;
        m_wr_idx  = 5'd0;
        m_wr_data = 32'd0;
        g_alu     = 1'b0;
        g_ld      = 1'b0;
    endtask

    task automatic predict();
        bit ld_first;
        ld_first = wb_if.ld_valid && ((starve_m >= STARVE_LIMIT) || !wb_if.alu_valid);
        g_ld  = ld_first;
        g_alu = wb_if.alu_valid && !ld_first;
    endtask

    function automatic bit exp_busy(input logic [4:0] idx);
        bit b;
        b = busy_m[idx];
`ifdef GP_WB_FORWARD_EN
        if (m_wr_en && (m_wr_idx == idx)) b = 1'b0;
`endif
        return b;
    endfunction

    task automatic idle();
        wb_if.alu_valid = 1'b0;
        wb_if.alu_idx   = 5'd0;
        wb_if.alu_data  = 32'd0;
        wb_if.ld_valid  = 1'b0;
        wb_if.ld_idx    = 5'd0;
        wb_if.ld_data   = 32'd0;
        alloc_en        = 1'b0;
        alloc_idx       = 5'd0;
        chk_idx_1       = 5'd0;
        chk_idx_2       = 5'd0;
    endtask

    // Advance one clock: model follows the rising edge, returns at the falling edge.
    task automatic tick();
        predict();
        @(posedge clk);
        if (m_wr_en) busy_m[m_wr_idx] = 1'b0;
        if (alloc_en && (alloc_idx != 5'd0)) busy_m[alloc_idx] = 1'b1;
        if (g_alu) begin
            m_wr_en = (wb_if.alu_idx != 5'd0); m_wr_idx = wb_if.alu_idx; m_wr_data = wb_if.alu_data;
        end else if (g_ld) begin
            m_wr_en = (wb_if.ld_idx != 5'd0); m_wr_idx = wb_if.ld_idx; m_wr_data = wb_if.ld_data;
        end else begin
            m_wr_en = 1'b0;
        end
        if (!wb_if.ld_valid || g_ld) starve_m = 0;
        else if (starve_m < STARVE_LIMIT) starve_m++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        chk_idx_1 = 5'd3;
        model_reset();
        #12;
        n_cmp++; if (wb_if.wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %0b want 0", wb_if.wr_en); end
        n_cmp++; if (wb_if.wr_idx !== 5'd0) begin n_fail++; $display("FAIL reset_wr_idx: got %0d want 0", wb_if.wr_idx); end
        n_cmp++; if (wb_if.wr_data !== 32'd0) begin n_fail++; $display("FAIL reset_wr_data: got %h want 0", wb_if.wr_data); end
        n_cmp++; if (busy_1 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy_1); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_alu();
        idle();
        wb_if.alu_valid = 1'b1; wb_if.alu_idx = 5'd5; wb_if.alu_data = 32'hDEADBEEF;
        #1;
        n_cmp++; if (wb_if.alu_ready !== 1'b1) begin n_fail++; $display("FAIL single_alu_ready: got %0b want 1", wb_if.alu_ready); end
        n_cmp++; if (wb_if.ld_ready !== 1'b0) begin n_fail++; $display("FAIL single_ld_ready: got %0b want 0", wb_if.ld_ready); end
        tick();
        idle();
        #1;
        n_cmp++; if (wb_if.wr_en !== 1'b1) begin n_fail++; $display("FAIL single_wr_en: got %0b want 1", wb_if.wr_en); end
        n_cmp++; if (wb_if.wr_idx !== 5'd5) begin n_fail++; $display("FAIL single_wr_idx: got %0d want 5", wb_if.wr_idx); end
        n_cmp++; if (wb_if.wr_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_wr_data: got %h want deadbeef", wb_if.wr_data); end
        tick();
        n_cmp++; if (wb_if.wr_en !== 1'b0) begin n_fail++; $display("FAIL single_wr_en_drop: got %0b want 0", wb_if.wr_en); end
    endtask

    task automatic test_starvation();
        logic [4:0]  exp_idx;
        logic [31:0] exp_data;
        bit          exp_ld;
        idle();
        wb_if.ld_valid = 1'b1;
        wb_if.ld_idx   = 5'($urandom_range(1, 31));
        wb_if.ld_data  = $urandom;
        for (int i = 0; i <= STARVE_LIMIT + 1; i++) begin
            wb_if.alu_valid = 1'b1;
            wb_if.alu_idx   = 5'($urandom_range(1, 31));
            wb_if.alu_data  = $urandom;
            #1;
            exp_ld = (i == STARVE_LIMIT);
            n_cmp++; if (wb_if.ld_ready !== exp_ld) begin n_fail++; $display("FAIL starve_ld_ready[%0d]: got %0b want %0b", i, wb_if.ld_ready, exp_ld); end
            n_cmp++; if (wb_if.alu_ready !== !exp_ld) begin n_fail++; $display("FAIL starve_alu_ready[%0d]: got %0b want %0b", i, wb_if.alu_ready, !exp_ld); end
            exp_idx  = exp_ld ? wb_if.ld_idx : wb_if.alu_idx;
            exp_data = exp_ld ? wb_if.ld_data : wb_if.alu_data;
            tick();
            n_cmp++; if (wb_if.wr_idx !== exp_idx || wb_if.wr_data !== exp_data) begin
                n_fail++; $display("FAIL starve_wr[%0d]: got %0d/%h want %0d/%h", i, wb_if.wr_idx, wb_if.wr_data, exp_idx, exp_data);
            end
            if (exp_ld) begin
                wb_if.ld_idx  = 5'($urandom_range(1, 31));
                wb_if.ld_data = $urandom;
            end
        end
        idle();
        tick();
    endtask

    task automatic test_scoreboard();
        logic [31:0] d;
        idle();
        alloc_en = 1'b1; alloc_idx = 5'd7;
        tick();
        alloc_en = 1'b0; chk_idx_1 = 5'd7;
        #1;
        n_cmp++; if (busy_1 !== 1'b1) begin n_fail++; $display("FAIL sb_busy_set: got %0b want 1", busy_1); end
        tick();
        n_cmp++; if (busy_1 !== 1'b1) begin n_fail++; $display("FAIL sb_busy_hold: got %0b want 1", busy_1); end
        d = $urandom;
        wb_if.alu_valid = 1'b1; wb_if.alu_idx = 5'd7; wb_if.alu_data = d;
        tick();
        wb_if.alu_valid = 1'b0;
        #1;
        n_cmp++; if (wb_if.wr_en !== 1'b1 || wb_if.wr_idx !== 5'd7) begin n_fail++; $display("FAIL sb_wr: got %0b/%0d want 1/7", wb_if.wr_en, wb_if.wr_idx); end
`ifdef GP_WB_FORWARD_EN
        n_cmp++; if (busy_1 !== 1'b0) begin n_fail++; $display("FAIL sb_busy_fwd: got %0b want 0", busy_1); end
        n_cmp++; if (fwd_data_1 !== d) begin n_fail++; $display("FAIL sb_fwd_data: got %h want %h", fwd_data_1, d); end
`else
        n_cmp++; if (busy_1 !== 1'b1) begin n_fail++; $display("FAIL sb_busy_wr_cycle: got %0b want 1", busy_1); end
`endif
        tick();
        n_cmp++; if (busy_1 !== 1'b0) begin n_fail++; $display("FAIL sb_busy_clear: got %0b want 0", busy_1); end
    endtask

    task automatic test_collision();
        idle();
        alloc_en = 1'b1; alloc_idx = 5'd9;
        tick();
        alloc_en = 1'b0;
        wb_if.alu_valid = 1'b1; wb_if.alu_idx = 5'd9; wb_if.alu_data = $urandom;
        tick();
        wb_if.alu_valid = 1'b0;
        alloc_en = 1'b1; alloc_idx = 5'd9; chk_idx_2 = 5'd9;
        #1;
        n_cmp++; if (wb_if.wr_en !== 1'b1 || wb_if.wr_idx !== 5'd9) begin n_fail++; $display("FAIL coll_wr: got %0b/%0d want 1/9", wb_if.wr_en, wb_if.wr_idx); end
        tick();
        alloc_en = 1'b0;
        #1;
        n_cmp++; if (busy_2 !== 1'b1) begin n_fail++; $display("FAIL coll_busy: got %0b want 1", busy_2); end
        tick();
        n_cmp++; if (busy_2 !== 1'b1) begin n_fail++; $display("FAIL coll_busy_hold: got %0b want 1", busy_2); end
    endtask

    task automatic test_x0();
        idle();
        wb_if.alu_valid = 1'b1; wb_if.alu_idx = 5'd0; wb_if.alu_data = 32'h0000_1234;
        #1;
        n_cmp++; if (wb_if.alu_ready !== 1'b1) begin n_fail++; $display("FAIL x0_ready: got %0b want 1", wb_if.alu_ready); end
        tick();
        wb_if.alu_valid = 1'b0;
        alloc_en = 1'b1; alloc_idx = 5'd0; chk_idx_1 = 5'd0; chk_idx_2 = 5'd0;
        #1;
        n_cmp++; if (wb_if.wr_en !== 1'b0) begin n_fail++; $display("FAIL x0_wr_en: got %0b want 0", wb_if.wr_en); end
        tick();
        alloc_en = 1'b0;
        #1;
        n_cmp++; if (busy_1 !== 1'b0 || busy_2 !== 1'b0) begin n_fail++; $display("FAIL x0_busy: got %0b%0b want 00", busy_1, busy_2); end
    endtask

    task automatic test_async_reset();
        bit exp_ld;
        idle();
        alloc_en = 1'b1; alloc_idx = 5'd3;
        tick();
        alloc_en = 1'b0;
        wb_if.alu_valid = 1'b1; wb_if.alu_idx = 5'd3; wb_if.alu_data = $urandom;
        wb_if.ld_valid  = 1'b1; wb_if.ld_idx  = 5'd4; wb_if.ld_data  = $urandom;
        tick();
        chk_idx_1 = 5'd3; chk_idx_2 = 5'd3;
        #1;
        n_cmp++; if (wb_if.wr_en !== 1'b1) begin n_fail++; $display("FAIL arst_pre_wr_en: got %0b want 1", wb_if.wr_en); end
        n_cmp++; if (busy_1 !== exp_busy(5'd3)) begin n_fail++; $display("FAIL arst_pre_busy: got %0b want %0b", busy_1, exp_busy(5'd3)); end
        #1;
        rst = 1'b1;
        #1;
        n_cmp++; if (wb_if.wr_en !== 1'b0) begin n_fail++; $display("FAIL arst_wr_en: got %0b want 0", wb_if.wr_en); end
        n_cmp++; if (wb_if.wr_idx !== 5'd0) begin n_fail++; $display("FAIL arst_wr_idx: got %0d want 0", wb_if.wr_idx); end
        n_cmp++; if (wb_if.wr_data !== 32'd0) begin n_fail++; $display("FAIL arst_wr_data: got %h want 0", wb_if.wr_data); end
        n_cmp++; if (busy_1 !== 1'b0) begin n_fail++; $display("FAIL arst_busy: got %0b want 0", busy_1); end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i <= STARVE_LIMIT; i++) begin
            #1;
            exp_ld = (i == STARVE_LIMIT);
            n_cmp++; if (wb_if.ld_ready !== exp_ld) begin n_fail++; $display("FAIL arst_cnt_ld_ready[%0d]: got %0b want %0b", i, wb_if.ld_ready, exp_ld); end
            tick();
        end
        idle();
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            if (!wb_if.alu_valid || g_alu) begin
                wb_if.alu_valid = ($urandom_range(0, 3) != 0);
                wb_if.alu_idx   = 5'($urandom_range(0, 31));
                wb_if.alu_data  = $urandom;
            end
            if (!wb_if.ld_valid || g_ld) begin
                wb_if.ld_valid = ($urandom_range(0, 1) != 0);
                wb_if.ld_idx   = 5'($urandom_range(0, 31));
                wb_if.ld_data  = $urandom;
            end
            alloc_en  = ($urandom_range(0, 1) != 0);
            alloc_idx = 5'($urandom_range(0, 31));
            chk_idx_1 = ($urandom_range(0, 3) == 0) ? m_wr_idx : 5'($urandom_range(0, 31));
            chk_idx_2 = 5'($urandom_range(0, 31));
            #1;
            predict();
            n_cmp++; if (wb_if.alu_ready !== g_alu || wb_if.ld_ready !== g_ld) begin
                n_fail++; $display("FAIL rnd_ready[%0d]: got alu=%0b ld=%0b want alu=%0b ld=%0b", n, wb_if.alu_ready, wb_if.ld_ready, g_alu, g_ld);
            end
            n_cmp++; if (busy_1 !== exp_busy(chk_idx_1) || busy_2 !== exp_busy(chk_idx_2)) begin
                n_fail++; $display("FAIL rnd_busy[%0d]: got %0b%0b want %0b%0b", n, busy_1, busy_2, exp_busy(chk_idx_1), exp_busy(chk_idx_2));
            end
`ifdef GP_WB_FORWARD_EN
            if (m_wr_en) begin
                n_cmp++; if (fwd_data_1 !== m_wr_data || fwd_data_2 !== m_wr_data) begin
                    n_fail++; $display("FAIL rnd_fwd[%0d]: got %h/%h want %h", n, fwd_data_1, fwd_data_2, m_wr_data);
                end
            end
`endif
            tick();
            n_cmp++; if (wb_if.wr_en !== m_wr_en) begin n_fail++; $display("FAIL rnd_wr_en[%0d]: got %0b want %0b", n, wb_if.wr_en, m_wr_en); end
            if (m_wr_en) begin
                n_cmp++; if (wb_if.wr_idx !== m_wr_idx || wb_if.wr_data !== m_wr_data) begin
                    n_fail++; $display("FAIL rnd_wr[%0d]: got %0d/%h want %0d/%h", n, wb_if.wr_idx, wb_if.wr_data, m_wr_idx, m_wr_data);
                end
            end
        end
        idle();
        tick();
    endtask

    initial begin
        test_reset();
        test_single_alu();
        test_starvation();
        test_scoreboard();
        test_collision();
        test_x0();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/gp_writeback_arbiter.md
Name: gp_writeback_arbiter

Overview:
- Shares the register file's single write port between two writeback producers: the ALU/execute stage and the multi-cycle load unit.
- Tracks which registers have a write outstanding, with a 32-entry busy scoreboard, so decode can stall on read-after-write hazards.
- Sits between the execute/memory stages and GPRegisterFile.
- Its wr_* outputs connect directly to the register file's write_idx, write_data and write_enable inputs.

Parameters:
- STARVE_LIMIT, 4: consecutive cycles the load requester may be denied before it gets priority over the ALU. Legal range 1..15.
- CNT_W, 4: width of the starvation counter. Must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  asynchronous reset, active-high
- alu_valid  in  1  ALU writeback request
- alu_ready  out  1  ALU request granted this cycle
- alu_idx  in  5  ALU destination register
- alu_data  in  32  ALU result
- ld_valid  in  1  load writeback request
- ld_ready  out  1  load request granted this cycle
- ld_idx  in  5  load destination register
- ld_data  in  32  load result
- alloc_en  in  1  decode issued an instruction that writes a register
- alloc_idx  in  5  destination register of the issued instruction
- chk_idx_1  in  5  decode source register 1
- chk_idx_2  in  5  decode source register 2
- busy_1  out  1  source 1 has a write outstanding
- busy_2  out  1  source 2 has a write outstanding
- wr_en  out  1  register file write enable
- wr_idx  out  5  register file write index
- wr_data  out  32  register file write data

Behaviour:
- Reset:
  - wr_en, wr_idx and wr_data are 0.
  - The busy vector is all 0 and the starvation counter is 0.
  - Any write held in the output register is discarded.
  - Reset has immediate effect regardless of clk.
- Handshake:
  - A transfer occurs when valid && ready on the same cycle.
  - A requester holds valid, idx and data stable until it is granted.
  - The ready outputs are combinational from the two valids and the starvation counter.
- Arbitration (at most one grant per cycle):
  - Normal case: the ALU has fixed priority.
  - Starved case: when the counter == STARVE_LIMIT and ld_valid is high, the load is granted instead and alu_ready is 0.
  - A single requester is always granted.
- Starvation counter:
  - Cleared when ld_valid is 0 or the load is granted.
  - Otherwise increments, saturating at STARVE_LIMIT.
- Output register and latency:
  - On a grant, the winner's idx and data are registered.
  - wr_en is high for exactly the next cycle, so latency is 1 cycle from grant to wr_en.
  - Back-to-back grants produce consecutive wr_en cycles; throughput is 1 write per cycle.
- x0 handling:
  - A grant with idx == 0 completes the handshake, but wr_en stays 0 on the following cycle.
  - alloc_idx == 0 is ignored, and busy[0] is permanently 0.
- Scoreboard:
  - busy[alloc_idx] is set on a clock edge with alloc_en high.
  - busy[wr_idx] is cleared on the clock edge where wr_en is high, which is the same edge the register file commits the write.
  - If alloc and clear hit the same index on the same edge, alloc wins and the bit stays 1.
- busy_1 and busy_2 are combinational lookups: busy[chk_idx_1] and busy[chk_idx_2].
- Producers may grant writes to a register that is not marked busy; the arbiter does not check this.

Optional Feature:
- Macro: GP_WB_FORWARD_EN.
- When defined:
  - Adds outputs fwd_data_1 and fwd_data_2 (32 bits each), both driven from wr_data.
  - busy_n is additionally forced to 0 when wr_en is high and wr_idx == chk_idx_n (nonzero index).
  - Decode must then select fwd_data_n instead of the register file read, saving one stall cycle.
- When undefined: these ports do not exist and busy_n is the plain scoreboard bit.

Decomposition:
- Shared package holds:
  - REG_IDX_W = 5 and XLEN = 32;
  - the arbiter grant encoding constants GNT_NONE, GNT_ALU and GNT_LD.
- Sub-module gp_scoreboard: the 32-bit busy vector, set/clear logic and the two lookup ports.
- The arbiter, starvation counter and output register stay in the top level.

Test Plan:
- Only alu_valid with idx 5 and data 0xDEADBEEF → alu_ready = 1; the next cycle has wr_en = 1, wr_idx = 5, wr_data = 0xDEADBEEF; the following cycle has wr_en = 0.
- alu_valid and ld_valid held high continuously with STARVE_LIMIT = 4 → ALU granted for 4 cycles, load granted on cycle 5, counter back to 0, then ALU granted again.
- alloc_en with idx 7, then chk_idx_1 = 7 → busy_1 = 1 until the edge where wr_en = 1 and wr_idx = 7; busy_1 = 0 on the next cycle. With the forward macro, busy_1 = 0 and fwd_data_1 = wr_data during the wr_en cycle.
- Simultaneous alloc of idx 9 and wr_en retiring idx 9 → busy[9] remains 1.
- Grant with idx 0 and data 0x1234 → handshake completes, wr_en stays 0, busy_* for x0 reads 0.
- rst asserted mid-cycle while wr_en = 1 and busy[3] = 1 → wr_en, wr_idx, wr_data, busy and counter go to 0 immediately, without waiting for a clock edge.
